// File: rtl/l1_trigger_event_fifo_if.sv
// AXI4-Stream event channel between the trigger event FIFO and the readout path.
interface l1_trigger_event_fifo_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/l1_trigger_event_fifo.sv
// Turns per-beam trigger rising edges into timestamped events with retrigger
// holdoff, buffers them in a FIFO and streams them out with drop accounting.
module l1_trigger_event_fifo #(
  parameter int NBEAMS          = 2,
  parameter int HOLDOFF_BITS    = 8,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       aclk,
  input  logic                       reset_i,
  input  logic [NBEAMS-1:0]          trig_i,
  input  logic                       enable_i,
  input  logic [HOLDOFF_BITS-1:0]    holdoff_i,
  l1_trigger_event_fifo_if.master    evt,
  output logic [15:0]                dropped_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_OCC = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [31:0]                ts_q, ts_d, ts_r_q, ts_r_d;
  logic [NBEAMS-1:0]          trig_r_q, trig_r_d, trig_rr_q, trig_rr_d;
  logic [HOLDOFF_BITS-1:0]    ho_q [NBEAMS];
  logic [HOLDOFF_BITS-1:0]    ho_d [NBEAMS];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   mem_cnt_q, mem_cnt_d, occ_q, occ_d;
  logic [63:0]                mem_q [DEPTH];
  logic                       out_valid_q, out_valid_d;
  logic [63:0]                out_data_q, out_data_d;
  logic [7:0]                 pend_q, pend_d;
  logic [15:0]                dropped_q, dropped_d;

  logic [NBEAMS-1:0] edge_s, qual_s;
  logic [15:0]       mask_s;
  logic [63:0]       wr_data_s;
  logic              full_s, push_s, drop_s, pop_s, load_s;

  // Next-state logic: edge detect, holdoff, push/drop decision and output stage.
  // Occupancy includes the output register, so the whole path holds DEPTH events.
  always_comb begin
    ts_d      = ts_q + 32'd1;
    ts_r_d    = ts_q;
    trig_r_d  = trig_i;
    trig_rr_d = trig_r_q;
    edge_s    = trig_r_q & ~trig_rr_q;
    qual_s    = {NBEAMS{1'b0}};
    for (int b = 0; b < NBEAMS; b++) begin
      qual_s[b] = edge_s[b] & enable_i & (ho_q[b] == {HOLDOFF_BITS{1'b0}});
      if (qual_s[b]) begin
        ho_d[b] = holdoff_i;
      end else if (ho_q[b] != {HOLDOFF_BITS{1'b0}}) begin
        ho_d[b] = ho_q[b] - HOLDOFF_BITS'(1);
      end else begin
        ho_d[b] = ho_q[b];
      end
    end

    mask_s               = 16'h0000;
    mask_s[NBEAMS-1:0]   = qual_s;
    wr_data_s            = {8'h00, pend_q, mask_s, ts_r_q};
    full_s               = (occ_q == FULL_OCC);
    push_s               = (|qual_s) & ~full_s;
    drop_s               = (|qual_s) & full_s;
    pop_s                = out_valid_q & evt.tready;
    load_s               = (~out_valid_q | pop_s) & (mem_cnt_q != {(FIFO_DEPTH_LOG2+1){1'b0}});

    wr_ptr_d  = wr_ptr_q + FIFO_DEPTH_LOG2'(push_s);
    rd_ptr_d  = rd_ptr_q + FIFO_DEPTH_LOG2'(load_s);
    mem_cnt_d = mem_cnt_q + (FIFO_DEPTH_LOG2+1)'(push_s) - (FIFO_DEPTH_LOG2+1)'(load_s);
    occ_d     = occ_q + (FIFO_DEPTH_LOG2+1)'(push_s) - (FIFO_DEPTH_LOG2+1)'(pop_s);

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop_s) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end

    if (push_s) begin
      pend_d = 8'h00;
    end else if (drop_s && (pend_q != 8'hFF)) begin
      pend_d = pend_q + 8'd1;
    end else begin
      pend_d = pend_q;
    end

    if (drop_s && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      ts_q        <= 32'd0;
      ts_r_q      <= 32'd0;
      trig_r_q    <= {NBEAMS{1'b0}};
      trig_rr_q   <= {NBEAMS{1'b0}};
      for (int b = 0; b < NBEAMS; b++) ho_q[b] <= {HOLDOFF_BITS{1'b0}};
      wr_ptr_q    <= {FIFO_DEPTH_LOG2{1'b0}};
      rd_ptr_q    <= {FIFO_DEPTH_LOG2{1'b0}};
      mem_cnt_q   <= {(FIFO_DEPTH_LOG2+1){1'b0}};
      occ_q       <= {(FIFO_DEPTH_LOG2+1){1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      pend_q      <= 8'h00;
      dropped_q   <= 16'h0000;
    end else begin
      ts_q        <= ts_d;
      ts_r_q      <= ts_r_d;
      trig_r_q    <= trig_r_d;
      trig_rr_q   <= trig_rr_d;
      for (int b = 0; b < NBEAMS; b++) ho_q[b] <= ho_d[b];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pend_q      <= pend_d;
      dropped_q   <= dropped_d;
    end
  end

  // Event storage; contents are don't-care until written, pointers guard reads.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
  end

  assign evt.tdata  = out_data_q;
  assign evt.tvalid = out_valid_q;
  assign dropped_o  = dropped_q;

endmodule
